pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It sits beside the decode stage and watches source/destination register addresses and write enables in D, E, M and W. From these it produces stall, flush and forwarding selects for the F/D/E pipeline registers and the D-stage branch comparator. It also sequences the multi-cycle multiply/divide unit with a busy counter, so HI/LO consumers stall until the result is ready.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 29 ++
 rtl/pipe_hazard_ctrl_mdu_seq.sv | 103 ++++++++++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - forwarding select encodings for the E-stage ALU operand muxes
//   - multiply/divide sequencer state encodings
//   - default multiply/divide latencies
//   - reg_match helper: address compare where $0 never matches
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 32;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_BUSY = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_t;

    // $0 is hard-wired to zero, so it is never a real dependence.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != 5'd0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq
// Multiply/divide busy sequencer. An issue in E loads a down-counter with
// (latency - 1); the FSM stays BUSY until the counter reaches 1, then spends
// one cycle in DONE (md_done pulse) before returning to IDLE. An issue seen
// in DONE restarts directly.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   md_start      E holds mult/multu/div/divu
//   md_is_div     1 = divide latency, 0 = multiply latency
//   md_busy       high in BUSY only
//   md_done       one-cycle pulse when HI/LO become valid
// Also holds mdu_seq_chk, which flags an issue arriving while BUSY.
// ---------------------------------------------------------------------------
module mdu_seq
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy,
    output logic md_done
);

    mdu_state_t       state_r;
    mdu_state_t       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] load_s;

    assign load_s = md_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MDU_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            MDU_IDLE, MDU_DONE: begin
                if (md_start) begin
                    state_s = MDU_BUSY;
                    cnt_s   = load_s;
                end else begin
                    state_s = MDU_IDLE;
                end
            end
            MDU_BUSY: begin
                // An issue here is impossible (D is stalled) and is ignored.
                cnt_s = cnt_r - CNT_W'(1);
                if (cnt_r <= CNT_W'(2)) begin
                    state_s = MDU_DONE;
                end else begin
                    state_s = MDU_BUSY;
                end
            end
            default: begin
                state_s = MDU_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Status is forced low while reset is held, even before the first edge.
    assign md_busy = (state_r == MDU_BUSY) && !rst;
    assign md_done = (state_r == MDU_DONE) && !rst;

    mdu_seq_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .md_busy  (md_busy),
        .md_start (md_start)
    );

endmodule

// Flags a multiply/divide issue arriving while the unit is still busy.
module mdu_seq_chk (
    input logic clk,
    input logic rst,
    input logic md_busy,
    input logic md_start
);

    a_no_start_while_busy : assert property (
        @(posedge clk) disable iff (rst) !(md_busy && md_start)
    );

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard controller for the five-stage MIPS pipeline: stall/flush of the
// F/D/E pipeline registers, E-stage ALU forwarding, D-stage branch
// comparator forwarding, and HI/LO interlock via the mdu_seq sequencer.
// Configuration macro: PIPE_FORWARD_EN. Defined -> forwarding muxes active,
// load-use and branch stalls. Undefined -> no forwarding; any RAW dependence
// of D on a pending write in E or M stalls until the producer is in W.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rs_D, rt_D / rs_E, rt_E       source registers in D / E
//   reg_src3_E/M/W, reg_we_E/M/W  destination register and write enable
//   mem_to_reg_E/M                load in E / M
//   branch_D, branch_taken_D      branch reading rs/rt in D; resolved taken
//   md_start_E, md_is_div_E       mult/div issue in E; divide select
//   hilo_use_D                    HI/LO consumer in D
//   stall_F, stall_D, flush_D, flush_E   pipeline register control
//   fwd_a_E, fwd_b_E              ALU operand select (RF / W / M)
//   fwd_a_D, fwd_b_D              branch comparator operand from M
//   md_busy, md_done              multiply/divide status
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [4:0] rs_E,
    input  logic [4:0] rt_E,
    input  logic [4:0] reg_src3_E,
    input  logic [4:0] reg_src3_M,
    input  logic [4:0] reg_src3_W,
    input  logic       reg_we_E,
    input  logic       reg_we_M,
    input  logic       reg_we_W,
    input  logic       mem_to_reg_E,
    input  logic       mem_to_reg_M,
    input  logic       branch_D,
    input  logic       branch_taken_D,
    input  logic       md_start_E,
    input  logic       md_is_div_E,
    input  logic       hilo_use_D,
    output logic       stall_F,
    output logic       stall_D,
    output logic       flush_D,
    output logic       flush_E,
    output logic [1:0] fwd_a_E,
    output logic [1:0] fwd_b_E,
    output logic       fwd_a_D,
    output logic       fwd_b_D,
    output logic       md_busy,
    output logic       md_done
);

    logic       dep_e_s;
    logic       dep_m_s;
    logic       raw_stall_s;
    logic       md_stall_s;
    logic       stall_s;
    logic [1:0] fwd_a_e_s;
    logic [1:0] fwd_b_e_s;
    logic       fwd_a_d_s;
    logic       fwd_b_d_s;

`ifndef PIPE_FORWARD_EN
    logic unused_fwd_s;
    assign unused_fwd_s = ^{rs_E, rt_E, reg_src3_W, reg_we_W,
                            mem_to_reg_E, mem_to_reg_M, branch_D};
`endif

    mdu_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_mdu_seq (
        .clk       (clk),
        .rst       (rst),
        .md_start  (md_start_E),
        .md_is_div (md_is_div_E),
        .md_busy   (md_busy),
        .md_done   (md_done)
    );

    // Dependence detection, forwarding selects and raw stall decision.
    always_comb begin
        dep_e_s     = reg_match(reg_src3_E, rs_D) || reg_match(reg_src3_E, rt_D);
        dep_m_s     = reg_match(reg_src3_M, rs_D) || reg_match(reg_src3_M, rt_D);
        fwd_a_e_s   = FWD_RF;
        fwd_b_e_s   = FWD_RF;
        fwd_a_d_s   = 1'b0;
        fwd_b_d_s   = 1'b0;
        raw_stall_s = 1'b0;
`ifdef PIPE_FORWARD_EN
        // M is the younger producer, so it wins over W.
        if (reg_we_M && reg_match(reg_src3_M, rs_E)) begin
            fwd_a_e_s = FWD_M;
        end else if (reg_we_W && reg_match(reg_src3_W, rs_E)) begin
            fwd_a_e_s = FWD_W;
        end else begin
            fwd_a_e_s = FWD_RF;
        end
        if (reg_we_M && reg_match(reg_src3_M, rt_E)) begin
            fwd_b_e_s = FWD_M;
        end else if (reg_we_W && reg_match(reg_src3_W, rt_E)) begin
            fwd_b_e_s = FWD_W;
        end else begin
            fwd_b_e_s = FWD_RF;
        end
        // W is covered by register-file write-before-read.
        fwd_a_d_s   = reg_we_M && reg_match(reg_src3_M, rs_D);
        fwd_b_d_s   = reg_we_M && reg_match(reg_src3_M, rt_D);
        // Load data is not available until W; the branch comparator only
        // sees M results, so an E producer or an M load must wait.
        raw_stall_s = (mem_to_reg_E && dep_e_s) ||
                      (branch_D && ((reg_we_E && dep_e_s) || (mem_to_reg_M && dep_m_s)));
`else
        raw_stall_s = (reg_we_E && dep_e_s) || (reg_we_M && dep_m_s);
`endif
        md_stall_s  = hilo_use_D && (md_busy || md_start_E);
        stall_s     = raw_stall_s || md_stall_s;
    end

    // Output drive; reset forces bubbles into D and E and clears selects.
    always_comb begin
        if (rst) begin
            stall_F = 1'b0;
            stall_D = 1'b0;
            flush_D = 1'b1;
            flush_E = 1'b1;
            fwd_a_E = FWD_RF;
            fwd_b_E = FWD_RF;
            fwd_a_D = 1'b0;
            fwd_b_D = 1'b0;
        end else begin
            stall_F = stall_s;
            stall_D = stall_s;
            // A stalled branch keeps its slot and re-resolves next cycle.
            flush_D = branch_taken_D && !stall_s;
            flush_E = stall_s;
            fwd_a_E = fwd_a_e_s;
            fwd_b_E = fwd_b_e_s;
            fwd_a_D = fwd_a_d_s;
            fwd_b_D = fwd_b_d_s;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. Expected values are hand-computed;
// those that depend on PIPE_FORWARD_EN follow the same macro.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [4:0] rs_D, rt_D, rs_E, rt_E;
    logic [4:0] reg_src3_E, reg_src3_M, reg_src3_W;
    logic       reg_we_E, reg_we_M, reg_we_W;
    logic       mem_to_reg_E, mem_to_reg_M;
    logic       branch_D, branch_taken_D;
    logic       md_start_E, md_is_div_E, hilo_use_D;
    logic       stall_F, stall_D, flush_D, flush_E;
    logic [1:0] fwd_a_E, fwd_b_E;
    logic       fwd_a_D, fwd_b_D;
    logic       md_busy, md_done;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rs_D           (rs_D),
        .rt_D           (rt_D),
        .rs_E           (rs_E),
        .rt_E           (rt_E),
        .reg_src3_E     (reg_src3_E),
        .reg_src3_M     (reg_src3_M),
        .reg_src3_W     (reg_src3_W),
        .reg_we_E       (reg_we_E),
        .reg_we_M       (reg_we_M),
        .reg_we_W       (reg_we_W),
        .mem_to_reg_E   (mem_to_reg_E),
        .mem_to_reg_M   (mem_to_reg_M),
        .branch_D       (branch_D),
        .branch_taken_D (branch_taken_D),
        .md_start_E     (md_start_E),
        .md_is_div_E    (md_is_div_E),
        .hilo_use_D     (hilo_use_D),
        .stall_F        (stall_F),
        .stall_D        (stall_D),
        .flush_D        (flush_D),
        .flush_E        (flush_E),
        .fwd_a_E        (fwd_a_E),
        .fwd_b_E        (fwd_b_E),
        .fwd_a_D        (fwd_a_D),
        .fwd_b_D        (fwd_b_D),
        .md_busy        (md_busy),
        .md_done        (md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_stall(input string tag, input logic exp);
        check({tag, "_stall_F"}, {1'b0, stall_F}, {1'b0, exp});
        check({tag, "_stall_D"}, {1'b0, stall_D}, {1'b0, exp});
        check({tag, "_flush_E"}, {1'b0, flush_E}, {1'b0, exp});
    endtask

    task automatic clear_inputs();
        rs_D = 5'd0; rt_D = 5'd0; rs_E = 5'd0; rt_E = 5'd0;
        reg_src3_E = 5'd0; reg_src3_M = 5'd0; reg_src3_W = 5'd0;
        reg_we_E = 1'b0; reg_we_M = 1'b0; reg_we_W = 1'b0;
        mem_to_reg_E = 1'b0; mem_to_reg_M = 1'b0;
        branch_D = 1'b0; branch_taken_D = 1'b0;
        md_start_E = 1'b0; md_is_div_E = 1'b0; hilo_use_D = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset with a would-be forward present ----------
        rst = 1'b1;
        clear_inputs();
        reg_we_M = 1'b1; reg_src3_M = 5'd3; rs_E = 5'd3;
        mem_to_reg_E = 1'b1; reg_we_E = 1'b1; reg_src3_E = 5'd6; rs_D = 5'd6;
        @(negedge clk);
        check("rst_stall_F", {1'b0, stall_F}, 2'b00);
        check("rst_stall_D", {1'b0, stall_D}, 2'b00);
        check("rst_flush_D", {1'b0, flush_D}, 2'b01);
        check("rst_flush_E", {1'b0, flush_E}, 2'b01);
        check("rst_fwd_a_E", fwd_a_E, 2'b00);
        check("rst_md_busy", {1'b0, md_busy}, 2'b00);
        check("rst_md_done", {1'b0, md_done}, 2'b00);

        next_cycle();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        check_stall("idle", 1'b0);
        check("idle_flush_D", {1'b0, flush_D}, 2'b00);

        // ---------------- E forwarding priority --------------------------
        next_cycle();
        reg_we_M = 1'b1; reg_src3_M = 5'd3; reg_we_W = 1'b1; reg_src3_W = 5'd3; rs_E = 5'd3;
        @(negedge clk);
        check("fwd_m_over_w", fwd_a_E, FWD_ON ? 2'b10 : 2'b00);
        check("fwd_b_none", fwd_b_E, 2'b00);
        next_cycle();
        reg_we_M = 1'b0;
        @(negedge clk);
        check("fwd_w_only", fwd_a_E, FWD_ON ? 2'b01 : 2'b00);
        next_cycle();
        rs_E = 5'd0; rt_E = 5'd3;
        @(negedge clk);
        check("fwd_rs_zero", fwd_a_E, 2'b00);
        check("fwd_b_w", fwd_b_E, FWD_ON ? 2'b01 : 2'b00);

        // ---------------- load-use ---------------------------------------
        next_cycle();
        clear_inputs();
        mem_to_reg_E = 1'b1; reg_we_E = 1'b1; reg_src3_E = 5'd5; rs_D = 5'd5;
        @(negedge clk);
        check_stall("lu_c0", 1'b1);
        next_cycle();
        clear_inputs();
        mem_to_reg_M = 1'b1; reg_we_M = 1'b1; reg_src3_M = 5'd5; rs_D = 5'd5;
        @(negedge clk);
        check_stall("lu_c1", FWD_ON ? 1'b0 : 1'b1);
        next_cycle();
        clear_inputs();
        reg_we_W = 1'b1; reg_src3_W = 5'd5; rs_E = 5'd5;
        @(negedge clk);
        check("lu_fwd_w", fwd_a_E, FWD_ON ? 2'b01 : 2'b00);
        check_stall("lu_c2", 1'b0);

        // ---------------- branch dependence on ALU result ----------------
        next_cycle();
        clear_inputs();
        branch_D = 1'b1; rs_D = 5'd4; reg_we_E = 1'b1; reg_src3_E = 5'd4;
        @(negedge clk);
        check_stall("br_alu_c0", 1'b1);
        next_cycle();
        clear_inputs();
        branch_D = 1'b1; rs_D = 5'd4; reg_we_M = 1'b1; reg_src3_M = 5'd4;
        @(negedge clk);
        check_stall("br_alu_c1", FWD_ON ? 1'b0 : 1'b1);
        check("br_fwd_a_D", {1'b0, fwd_a_D}, FWD_ON ? 2'b01 : 2'b00);

        // ---------------- branch dependence on load ----------------------
        next_cycle();
        clear_inputs();
        branch_D = 1'b1; rt_D = 5'd4; reg_we_E = 1'b1; mem_to_reg_E = 1'b1; reg_src3_E = 5'd4;
        @(negedge clk);
        check_stall("br_lw_c0", 1'b1);
        next_cycle();
        clear_inputs();
        branch_D = 1'b1; rt_D = 5'd4; reg_we_M = 1'b1; mem_to_reg_M = 1'b1; reg_src3_M = 5'd4;
        @(negedge clk);
        check_stall("br_lw_c1", 1'b1);
        next_cycle();
        clear_inputs();
        branch_D = 1'b1; rt_D = 5'd4; reg_we_W = 1'b1; reg_src3_W = 5'd4;
        @(negedge clk);
        check_stall("br_lw_c2", 1'b0);
        check("br_lw_fwd_b_D", {1'b0, fwd_b_D}, 2'b00);

        // ---------------- taken branch, with and without stall -----------
        next_cycle();
        clear_inputs();
        branch_D = 1'b1; branch_taken_D = 1'b1; rs_D = 5'd7; rt_D = 5'd8;
        reg_we_E = 1'b1; reg_src3_E = 5'd9;
        @(negedge clk);
        check("taken_flush_D", {1'b0, flush_D}, 2'b01);
        check_stall("taken", 1'b0);
        next_cycle();
        mem_to_reg_E = 1'b1; reg_src3_E = 5'd7;
        @(negedge clk);
        check("taken_lu_flush_D", {1'b0, flush_D}, 2'b00);
        check_stall("taken_lu", 1'b1);

        // ---------------- plain RAW on M producer ------------------------
        next_cycle();
        clear_inputs();
        reg_we_M = 1'b1; reg_src3_M = 5'd2; rs_D = 5'd2;
        @(negedge clk);
        check_stall("raw_m", FWD_ON ? 1'b0 : 1'b1);
        next_cycle();
        clear_inputs();
        reg_we_W = 1'b1; reg_src3_W = 5'd2; rs_D = 5'd2;
        @(negedge clk);
        check_stall("raw_w", 1'b0);

        // ---------------- register 0 never matches -----------------------
        next_cycle();
        clear_inputs();
        branch_D = 1'b1; reg_we_E = 1'b1; mem_to_reg_E = 1'b1;
        reg_we_M = 1'b1; reg_we_W = 1'b1;
        @(negedge clk);
        check_stall("zero_reg", 1'b0);
        check("zero_fwd_a_E", fwd_a_E, 2'b00);
        check("zero_fwd_a_D", {1'b0, fwd_a_D}, 2'b00);

        // ---------------- divide with HI/LO reader in D ------------------
        next_cycle();
        clear_inputs();
        md_start_E = 1'b1; md_is_div_E = 1'b1; hilo_use_D = 1'b1;
        @(negedge clk);
        check("div_c0_busy", {1'b0, md_busy}, 2'b00);
        check_stall("div_c0", 1'b1);
        for (int k = 1; k <= 30; k++) begin
            next_cycle();
            md_start_E = 1'b0;
            @(negedge clk);
            check($sformatf("div_c%0d_busy", k), {1'b0, md_busy}, 2'b01);
            check($sformatf("div_c%0d_done", k), {1'b0, md_done}, 2'b00);
            check($sformatf("div_c%0d_stall", k), {1'b0, stall_D}, 2'b01);
        end
        next_cycle();
        @(negedge clk);
        check("div_c31_done", {1'b0, md_done}, 2'b01);
        check("div_c31_busy", {1'b0, md_busy}, 2'b00);
        check_stall("div_c31", 1'b0);
        next_cycle();
        @(negedge clk);
        check("div_c32_done", {1'b0, md_done}, 2'b00);
        check_stall("div_c32", 1'b0);

        // ---------------- multiply latency -------------------------------
        next_cycle();
        clear_inputs();
        md_start_E = 1'b1; hilo_use_D = 1'b1;
        @(negedge clk);
        check_stall("mul_c0", 1'b1);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            md_start_E = 1'b0;
            @(negedge clk);
            check($sformatf("mul_c%0d_busy", k), {1'b0, md_busy}, 2'b01);
            check($sformatf("mul_c%0d_done", k), {1'b0, md_done}, 2'b00);
        end
        next_cycle();
        @(negedge clk);
        check("mul_c4_done", {1'b0, md_done}, 2'b01);
        check("mul_c4_busy", {1'b0, md_busy}, 2'b00);
        next_cycle();
        @(negedge clk);
        check("mul_c5_done", {1'b0, md_done}, 2'b00);

        // ---------------- reset mid-multiply -----------------------------
        next_cycle();
        clear_inputs();
        md_start_E = 1'b1; hilo_use_D = 1'b1;
        @(negedge clk);
        next_cycle();
        md_start_E = 1'b0;
        @(negedge clk);
        check("rmul_c1_busy", {1'b0, md_busy}, 2'b01);
        next_cycle();
        @(negedge clk);
        check("rmul_c2_busy", {1'b0, md_busy}, 2'b01);
        rst = 1'b1;
        #1;
        check("rmul_rst_busy", {1'b0, md_busy}, 2'b00);
        check("rmul_rst_flush_D", {1'b0, flush_D}, 2'b01);
        check("rmul_rst_flush_E", {1'b0, flush_E}, 2'b01);
        check("rmul_rst_stall_F", {1'b0, stall_F}, 2'b00);
        next_cycle();
        @(negedge clk);
        check("rmul_rst2_busy", {1'b0, md_busy}, 2'b00);
        check("rmul_rst2_flush_D", {1'b0, flush_D}, 2'b01);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rmul_post_busy", {1'b0, md_busy}, 2'b00);
        check("rmul_post_done", {1'b0, md_done}, 2'b00);
        check_stall("rmul_post", 1'b0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("rmul_idle%0d_done", k), {1'b0, md_done}, 2'b00);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
